round_sequencer: RTL and testbench

//  Game-round controller that sequences the time-bar block. Generates its one_ms_tick, drives its

---
 rtl/round_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_round_sequencer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_sequencer.sv
// ---------------------------------------------------------------------------
// round_sequencer
//  Game-round controller driving the time-bar block. It runs the round flow
//  MENU -> 3-2-1 COUNTDOWN -> PLAY -> LEVEL_UP / GAME_OVER, generates the
//  1 ms tick used by the time bar, and exposes countdown digit, level and an
//  encoded state for the text/overlay renderers.
//
//  Ports
//   clk          in   1  system/pixel clock
//   rst          in   1  synchronous reset, active-high
//   btn_start    in   1  debounced 1-cycle start/confirm pulse
//   player_fell  in   1  1-cycle pulse: player left the platforms
//   level_done   in   1  1-cycle pulse: level goal reached
//   elapsed      in   1  time-bar expired flag (level signal)
//   one_ms_tick  out  1  1-cycle pulse every CLK_PER_MS clk
//   bar_en       out  1  time-bar module enable
//   bar_start    out  1  time-bar start, 1-cycle pulse on PLAY entry
//   countdown    out  2  countdown digit 3..1, 0 outside COUNTDOWN
//   level        out  4  current level, 0-based, saturating
//   game_state   out  3  encoded state (0 MENU .. 4 GAME_OVER)
//   game_over    out  1  high while in GAME_OVER
//
//  Timing: the FSM registers the decision at the edge that samples an input;
//  the output register stage then presents it one edge later.
// ---------------------------------------------------------------------------
module round_sequencer #(
    parameter int CLK_PER_MS = 40000,
    parameter int COUNT_MS   = 1000,
    parameter int PAUSE_MS   = 500,
    parameter int MAX_LEVEL  = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       player_fell,
    input  logic       level_done,
    input  logic       elapsed,
    output logic       one_ms_tick,
    output logic       bar_en,
    output logic       bar_start,
    output logic [1:0] countdown,
    output logic [3:0] level,
    output logic [2:0] game_state,
    output logic       game_over
);

    localparam int DIV_W = (CLK_PER_MS > 2) ? $clog2(CLK_PER_MS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_PER_MS - 1);
    // The tick register is loaded one count early so it is high exactly
    // while the divider holds its last value.
    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(CLK_PER_MS - 2);
    localparam logic [9:0]       CNT_LAST = 10'(COUNT_MS - 1);
    localparam logic [9:0]       PSE_LAST = 10'(PAUSE_MS - 1);
    localparam logic [3:0]       LVL_MAX  = 4'(MAX_LEVEL);

    typedef enum logic [2:0] {
        S_MENU      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAY      = 3'd2,
        S_LEVEL_UP  = 3'd3,
        S_GAME_OVER = 3'd4
    } state_t;

    logic [DIV_W-1:0] div_r;
    state_t           state_r;
    logic [9:0]       ms_cnt_r;
    logic [1:0]       cd_r;
    logic [3:0]       lvl_r;
    logic [3:0]       lvl_next_s;

    // Saturating level increment used on LEVEL_UP entry.
    always_comb begin
        lvl_next_s = lvl_r;
        if (lvl_r >= LVL_MAX) begin
            lvl_next_s = LVL_MAX;
        end else begin
            lvl_next_s = lvl_r + 4'd1;
        end
    end

    // Free-running 1 ms divider; the FSM never clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r       <= '0;
            one_ms_tick <= 1'b0;
        end else begin
            if (div_r == DIV_LAST) begin
                div_r <= '0;
            end else begin
                div_r <= div_r + 1'b1;
            end
            one_ms_tick <= (div_r == DIV_PRE);
        end
    end

    // Round FSM: state, per-state millisecond counter, countdown digit, level.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= S_MENU;
            ms_cnt_r <= 10'd0;
            cd_r     <= 2'd0;
            lvl_r    <= 4'd0;
        end else begin
            case (state_r)
                S_MENU: begin
                    if (btn_start) begin
                        state_r  <= S_COUNTDOWN;
                        ms_cnt_r <= 10'd0;
                        cd_r     <= 2'd3;
                        lvl_r    <= 4'd0;
                    end else if (one_ms_tick) begin
                        ms_cnt_r <= ms_cnt_r + 10'd1;
                    end
                end
                S_COUNTDOWN: begin
                    // btn_start and a stale elapsed are deliberately ignored here.
                    if (one_ms_tick) begin
                        if (ms_cnt_r == CNT_LAST) begin
                            ms_cnt_r <= 10'd0;
                            if (cd_r > 2'd1) begin
                                cd_r <= cd_r - 2'd1;
                            end else begin
                                state_r <= S_PLAY;
                                cd_r    <= 2'd0;
                            end
                        end else begin
                            ms_cnt_r <= ms_cnt_r + 10'd1;
                        end
                    end
                end
                S_PLAY: begin
                    // Losing outranks winning when both arrive together.
                    if (player_fell || elapsed) begin
                        state_r  <= S_GAME_OVER;
                        ms_cnt_r <= 10'd0;
                    end else if (level_done) begin
                        state_r  <= S_LEVEL_UP;
                        ms_cnt_r <= 10'd0;
                        lvl_r    <= lvl_next_s;
                    end else if (one_ms_tick) begin
                        ms_cnt_r <= ms_cnt_r + 10'd1;
                    end
                end
                S_LEVEL_UP: begin
                    if (one_ms_tick) begin
                        if (ms_cnt_r == PSE_LAST) begin
                            state_r  <= S_COUNTDOWN;
                            ms_cnt_r <= 10'd0;
                            cd_r     <= 2'd3;
                        end else begin
                            ms_cnt_r <= ms_cnt_r + 10'd1;
                        end
                    end
                end
                S_GAME_OVER: begin
                    if (btn_start) begin
                        state_r  <= S_MENU;
                        ms_cnt_r <= 10'd0;
                    end else if (one_ms_tick) begin
                        ms_cnt_r <= ms_cnt_r + 10'd1;
                    end
                end
                default: begin
                    // Unused encodings recover to MENU.
                    state_r  <= S_MENU;
                    ms_cnt_r <= 10'd0;
                    cd_r     <= 2'd0;
                end
            endcase
        end
    end

    // Output register stage decoded from the FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            bar_en     <= 1'b0;
            bar_start  <= 1'b0;
            countdown  <= 2'd0;
            level      <= 4'd0;
            game_state <= 3'd0;
            game_over  <= 1'b0;
        end else begin
            level <= lvl_r;
            case (state_r)
                S_MENU: begin
                    bar_en     <= 1'b0;
                    bar_start  <= 1'b0;
                    countdown  <= 2'd0;
                    game_state <= 3'd0;
                    game_over  <= 1'b0;
                end
                S_COUNTDOWN: begin
                    bar_en     <= 1'b1;
                    bar_start  <= 1'b0;
                    countdown  <= cd_r;
                    game_state <= 3'd1;
                    game_over  <= 1'b0;
                end
                S_PLAY: begin
                    bar_en     <= 1'b1;
                    // game_state still shows the previous state on the first
                    // PLAY cycle, which makes bar_start a single pulse.
                    bar_start  <= (game_state != 3'd2);
                    countdown  <= 2'd0;
                    game_state <= 3'd2;
                    game_over  <= 1'b0;
                end
                S_LEVEL_UP: begin
                    bar_en     <= 1'b0;
                    bar_start  <= 1'b0;
                    countdown  <= 2'd0;
                    game_state <= 3'd3;
                    game_over  <= 1'b0;
                end
                S_GAME_OVER: begin
                    bar_en     <= 1'b0;
                    bar_start  <= 1'b0;
                    countdown  <= 2'd0;
                    game_state <= 3'd4;
                    game_over  <= 1'b1;
                end
                default: begin
                    bar_en     <= 1'b0;
                    bar_start  <= 1'b0;
                    countdown  <= 2'd0;
                    game_state <= 3'd0;
                    game_over  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_round_sequencer.sv
module tb_round_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_start;
    logic       player_fell;
    logic       level_done;
    logic       elapsed;
    logic       one_ms_tick;
    logic       bar_en;
    logic       bar_start;
    logic [1:0] countdown;
    logic [3:0] level;
    logic [2:0] game_state;
    logic       game_over;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard of expected game_state transitions, in order.
    logic [2:0] exp_q[$];
    logic [2:0] exp_e;
    logic [2:0] prev_gs;
    bit         mon_en = 1'b0;

    round_sequencer #(
        .CLK_PER_MS(10),
        .COUNT_MS  (3),
        .PAUSE_MS  (2),
        .MAX_LEVEL (15)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_start  (btn_start),
        .player_fell(player_fell),
        .level_done (level_done),
        .elapsed    (elapsed),
        .one_ms_tick(one_ms_tick),
        .bar_en     (bar_en),
        .bar_start  (bar_start),
        .countdown  (countdown),
        .level      (level),
        .game_state (game_state),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    // Monitor: every change of game_state is compared with the next expectation.
    always @(negedge clk) begin
        if (mon_en && (game_state !== prev_gs)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL state_seq: got %0d, no transition expected (from %0d)", game_state, prev_gs);
            end else begin
                exp_e = exp_q.pop_front();
                if (game_state !== exp_e) begin
                    n_fail++;
                    $display("FAIL state_seq: got %0d, expected %0d", game_state, exp_e);
                end
            end
            prev_gs = game_state;
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulse_btn();
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (one_ms_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (game_state === target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // MENU -> COUNTDOWN -> PLAY; reports whether PLAY was reached in time.
    task automatic start_round(output bit ok);
        bit t_ok;
        wait_tick(t_ok);
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd2);
        pulse_btn();
        wait_state(3'd2, 200, ok);
        ok = ok & t_ok;
    endtask

    task automatic test_reset();
        int n_ticks = 0;
        int first_tick = -1;
        int last_tick = -1;
        int gap_bad = 0;
        int idle_bad = 0;
        rst = 1'b1;
        btn_start = 1'b0;
        player_fell = 1'b0;
        level_done = 1'b0;
        elapsed = 1'b0;
        repeat (3) step();
        n_checks++;
        if (game_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d, expected 0", game_state); end
        n_checks++;
        if ({bar_en, bar_start, one_ms_tick, game_over} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b, expected 0000", {bar_en, bar_start, one_ms_tick, game_over});
        end
        n_checks++;
        if ({countdown, level} !== 6'd0) begin n_fail++; $display("FAIL reset_cd_level: got %0d/%0d, expected 0/0", countdown, level); end
        rst = 1'b0;
        prev_gs = game_state;
        mon_en = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (one_ms_tick === 1'b1) begin
                n_ticks++;
                if (first_tick < 0) first_tick = i;
                if (last_tick >= 0 && (i - last_tick) != 10) gap_bad++;
                last_tick = i;
            end
            if (game_state !== 3'd0 || bar_en !== 1'b0 || bar_start !== 1'b0 || level !== 4'd0) idle_bad++;
        end
        n_checks++;
        if (n_ticks != 10) begin n_fail++; $display("FAIL idle_tick_count: got %0d, expected 10", n_ticks); end
        n_checks++;
        if (gap_bad != 0) begin n_fail++; $display("FAIL idle_tick_period: %0d gaps differ from expected 10", gap_bad); end
        n_checks++;
        if (first_tick < 1 || first_tick > 10) begin n_fail++; $display("FAIL first_tick: got cycle %0d, expected 1..10", first_tick); end
        n_checks++;
        if (idle_bad != 0) begin n_fail++; $display("FAIL idle_outputs: %0d cycles nonzero, expected 0", idle_bad); end
    endtask

    task automatic test_countdown();
        int cnt[4] = '{0, 0, 0, 0};
        int bs = 0;
        int in_play = 0;
        int en_bad = 0;
        bit t_ok;
        logic first_bs = 1'b0;
        // Unused pulses in MENU must not be latched.
        level_done = 1'b1; player_fell = 1'b1;
        step();
        level_done = 1'b0; player_fell = 1'b0;
        repeat (5) step();
        n_checks++;
        if (game_state !== 3'd0) begin n_fail++; $display("FAIL menu_ignore: got %0d, expected 0", game_state); end
        wait_tick(t_ok);
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd2);
        btn_start = 1'b1;
        step();
        for (int i = 0; i < 200; i++) begin
            btn_start = (i == 40);
            step();
            if (game_state === 3'd1) begin
                if (one_ms_tick === 1'b1) cnt[countdown]++;
                if (bar_en !== 1'b1) en_bad++;
            end
            if (bar_start === 1'b1) bs++;
            if (game_state === 3'd2) begin
                if (in_play == 0) first_bs = bar_start;
                in_play++;
            end
            if (in_play >= 5) break;
        end
        btn_start = 1'b0;
        n_checks++;
        if (!t_ok || in_play < 5) begin n_fail++; $display("FAIL countdown_timeout: PLAY cycles %0d, expected 5", in_play); end
        n_checks++;
        if (cnt[3] != 3 || cnt[2] != 3 || cnt[1] != 3 || cnt[0] != 0) begin
            n_fail++; $display("FAIL countdown_ticks: got 3:%0d 2:%0d 1:%0d 0:%0d, expected 3 3 3 0", cnt[3], cnt[2], cnt[1], cnt[0]);
        end
        n_checks++;
        if (bs != 1 || first_bs !== 1'b1) begin n_fail++; $display("FAIL bar_start_pulse: got %0d pulses first=%b, expected 1 first=1", bs, first_bs); end
        n_checks++;
        if (en_bad != 0) begin n_fail++; $display("FAIL countdown_bar_en: %0d cycles low, expected 0", en_bad); end
        n_checks++;
        if ({bar_en, countdown, level} !== {1'b1, 2'd0, 4'd0}) begin
            n_fail++; $display("FAIL play_outputs: got en=%b cd=%0d lvl=%0d, expected 1 0 0", bar_en, countdown, level);
        end
    endtask

    task automatic test_game_over_elapsed();
        repeat (3) step();
        exp_q.push_back(3'd4);
        elapsed = 1'b1;
        step();
        n_checks++;
        if (game_state !== 3'd2) begin n_fail++; $display("FAIL elapsed_latency: got %0d one cycle after, expected 2", game_state); end
        step();
        n_checks++;
        if ({game_state, game_over, bar_en} !== {3'd4, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL game_over_outputs: got st=%0d go=%b en=%b, expected 4 1 0", game_state, game_over, bar_en);
        end
        n_checks++;
        if (level !== 4'd0) begin n_fail++; $display("FAIL game_over_level: got %0d, expected 0", level); end
        elapsed = 1'b0;
        repeat (4) step();
        exp_q.push_back(3'd0);
        pulse_btn();
        step();
        n_checks++;
        if ({game_state, game_over} !== {3'd0, 1'b0}) begin
            n_fail++; $display("FAIL back_to_menu: got st=%0d go=%b, expected 0 0", game_state, game_over);
        end
    endtask

    task automatic test_level_up();
        bit ok;
        bit t_ok;
        int lu_ticks = 0;
        bit reached = 1'b0;
        start_round(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL level_up_start: PLAY not reached, state %0d", game_state); end
        wait_tick(t_ok);
        exp_q.push_back(3'd3);
        exp_q.push_back(3'd1);
        level_done = 1'b1;
        step();
        level_done = 1'b0;
        // Bar is stopped now, so elapsed may be stale-high; it must be ignored.
        elapsed = 1'b1;
        step();
        n_checks++;
        if ({game_state, level, bar_en, bar_start} !== {3'd3, 4'd1, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL level_up_entry: got st=%0d lvl=%0d en=%b bs=%b, expected 3 1 0 0", game_state, level, bar_en, bar_start);
        end
        for (int i = 0; i < 60; i++) begin
            if (game_state === 3'd3 && one_ms_tick === 1'b1) lu_ticks++;
            step();
            if (game_state === 3'd1) begin
                reached = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!t_ok || !reached || lu_ticks != 2) begin
            n_fail++; $display("FAIL level_up_pause: got %0d ticks reached=%b, expected 2 ticks", lu_ticks, reached);
        end
        n_checks++;
        if ({countdown, bar_en} !== {2'd3, 1'b1}) begin
            n_fail++; $display("FAIL recount_entry: got cd=%0d en=%b, expected 3 1", countdown, bar_en);
        end
        repeat (5) step();
        elapsed = 1'b0;
        exp_q.push_back(3'd2);
        wait_state(3'd2, 200, ok);
        n_checks++;
        if (!ok || level !== 4'd1) begin n_fail++; $display("FAIL level_up_replay: got st=%0d lvl=%0d, expected 2 1", game_state, level); end
    endtask

    task automatic test_fell_priority();
        repeat (2) step();
        exp_q.push_back(3'd4);
        player_fell = 1'b1;
        level_done = 1'b1;
        step();
        player_fell = 1'b0;
        level_done = 1'b0;
        step();
        n_checks++;
        if ({game_state, level} !== {3'd4, 4'd1}) begin
            n_fail++; $display("FAIL fell_priority: got st=%0d lvl=%0d, expected 4 1", game_state, level);
        end
        exp_q.push_back(3'd0);
        pulse_btn();
        step();
        n_checks++;
        if (game_state !== 3'd0) begin n_fail++; $display("FAIL fell_to_menu: got %0d, expected 0", game_state); end
    endtask

    task automatic test_saturation();
        bit ok;
        bit ok3;
        int exp_lvl;
        int bad = 0;
        start_round(ok);
        n_checks++;
        if (!ok || level !== 4'd0) begin n_fail++; $display("FAIL sat_start: got st=%0d lvl=%0d, expected 2 0", game_state, level); end
        for (int i = 0; i < 16; i++) begin
            exp_lvl = (i + 1 > 15) ? 15 : i + 1;
            exp_q.push_back(3'd3);
            exp_q.push_back(3'd1);
            exp_q.push_back(3'd2);
            level_done = 1'b1;
            step();
            level_done = 1'b0;
            wait_state(3'd3, 10, ok3);
            wait_state(3'd2, 300, ok);
            if (!ok || !ok3 || level !== 4'(exp_lvl)) begin
                bad++;
                $display("FAIL level_step: round %0d got lvl=%0d st=%0d, expected lvl %0d", i, level, game_state, exp_lvl);
            end
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL level_saturation: %0d bad rounds, expected 0", bad); end
        exp_q.push_back(3'd4);
        player_fell = 1'b1;
        step();
        player_fell = 1'b0;
        wait_state(3'd4, 10, ok);
        n_checks++;
        if (!ok || level !== 4'd15) begin n_fail++; $display("FAIL sat_game_over: got st=%0d lvl=%0d, expected 4 15", game_state, level); end
        exp_q.push_back(3'd0);
        pulse_btn();
        wait_state(3'd0, 10, ok);
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit t_ok;
        wait_tick(t_ok);
        exp_q.push_back(3'd1);
        pulse_btn();
        repeat (20) step();
        n_checks++;
        if (!t_ok || game_state !== 3'd1) begin n_fail++; $display("FAIL mid_cd_setup: got %0d, expected 1", game_state); end
        exp_q.push_back(3'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if ({game_state, countdown, bar_en, one_ms_tick, game_over} !== 8'd0) begin
            n_fail++; $display("FAIL rst_mid_countdown: got st=%0d cd=%0d en=%b tk=%b, expected all 0", game_state, countdown, bar_en, one_ms_tick);
        end
        repeat (15) step();
        n_checks++;
        if (game_state !== 3'd0) begin n_fail++; $display("FAIL rst_stays_menu: got %0d, expected 0", game_state); end
        start_round(ok);
        exp_q.push_back(3'd3);
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd2);
        level_done = 1'b1;
        step();
        level_done = 1'b0;
        wait_state(3'd3, 10, ok);
        wait_state(3'd2, 300, ok);
        repeat (3) step();
        n_checks++;
        if (!ok || level !== 4'd1 || bar_en !== 1'b1) begin n_fail++; $display("FAIL mid_play_setup: got st=%0d lvl=%0d, expected 2 1", game_state, level); end
        exp_q.push_back(3'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if ({game_state, level, bar_en, bar_start, game_over, countdown} !== 12'd0) begin
            n_fail++; $display("FAIL rst_mid_play: got st=%0d lvl=%0d en=%b bs=%b, expected all 0", game_state, level, bar_en, bar_start);
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_game_over_elapsed();
        test_level_up();
        test_fell_priority();
        test_saturation();
        test_reset_mid();
        repeat (3) step();
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d transitions missing, expected 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
